// File: rtl/jtag_tap_sampled.sv
// jtag_tap_sampled
// IEEE 1149.1 TAP controller that runs entirely on the system clock. TCK is
// treated as data. Its rising and falling edges are detected in the clk_i
// domain and used as enables. The block provides:
//   - the 16-state TAP FSM
//   - an instruction register
//   - IDCODE, BYPASS and one 32-bit USER data register
// Opcodes other than IDCODE and USER select BYPASS.
//
// Ports:
//   clk_i          system clock (at least twice the TCK toggle rate)
//   rst_i          asynchronous active-high reset
//   jtag_tck_i     TCK level, already synchronous to clk_i
//   jtag_tms_i     TMS level
//   jtag_tdi_i     TDI level
//   jtag_trst_i    TRST, active-low, level-sensitive
//   jtag_tdo_o     TDO back to the bridge
//   tap_state_o    current TAP state (IEEE encoding)
//   ir_o           active instruction
//   user_dr_i      value captured into the USER DR in Capture-DR
//   user_dr_o      last value written through Update-DR with USER selected
//   user_update_o  one-cycle pulse when user_dr_o is written
module jtag_tap_sampled #(
  parameter int unsigned         IR_WIDTH     = 5,
  parameter logic [31:0]         IDCODE_VAL   = 32'h149511C3,
  parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0] INSTR_USER   = IR_WIDTH'(8)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                jtag_tck_i,
  input  logic                jtag_tms_i,
  input  logic                jtag_tdi_i,
  input  logic                jtag_trst_i,
  output logic                jtag_tdo_o,
  output logic [3:0]          tap_state_o,
  output logic [IR_WIDTH-1:0] ir_o,
  input  logic [31:0]         user_dr_i,
  output logic [31:0]         user_dr_o,
  output logic                user_update_o
);

  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SH_DR    = 4'h2,
    EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3,
    EX2_DR   = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SH_IR    = 4'hA,
    EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB,
    EX2_IR   = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_t;

  tap_state_t          state;
  tap_state_t          next_state;
  logic                tck_q;
  logic                rise;
  logic                fall;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [IR_WIDTH-1:0] ir;
  logic [31:0]         idcode_sr;
  logic [31:0]         user_sr;
  logic                bypass_sr;
  logic                tdo;
  logic [31:0]         user_dr;
  logic                user_update;
  logic                sel_idcode;
  logic                sel_user;
  logic                dr_lsb;

  // TCK edge detection in the clk_i domain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tck_q <= 1'b0;
    end else begin
      tck_q <= jtag_tck_i;
    end
  end

  assign rise = jtag_tck_i & ~tck_q;
  assign fall = ~jtag_tck_i & tck_q;

  // The data register is selected by the active instruction only.
  assign sel_idcode = (ir == INSTR_IDCODE);
  assign sel_user   = (ir == INSTR_USER);

  // Standard 1149.1 next-state graph, indexed by TMS.
  always_comb begin
    next_state = TLR;
    case (state)
      TLR:      next_state = jtag_tms_i ? TLR    : RTI;
      RTI:      next_state = jtag_tms_i ? SEL_DR : RTI;
      SEL_DR:   next_state = jtag_tms_i ? SEL_IR : CAP_DR;
      CAP_DR:   next_state = jtag_tms_i ? EX1_DR : SH_DR;
      SH_DR:    next_state = jtag_tms_i ? EX1_DR : SH_DR;
      EX1_DR:   next_state = jtag_tms_i ? UPD_DR : PAUSE_DR;
      PAUSE_DR: next_state = jtag_tms_i ? EX2_DR : PAUSE_DR;
      EX2_DR:   next_state = jtag_tms_i ? UPD_DR : SH_DR;
      UPD_DR:   next_state = jtag_tms_i ? SEL_DR : RTI;
      SEL_IR:   next_state = jtag_tms_i ? TLR    : CAP_IR;
      CAP_IR:   next_state = jtag_tms_i ? EX1_IR : SH_IR;
      SH_IR:    next_state = jtag_tms_i ? EX1_IR : SH_IR;
      EX1_IR:   next_state = jtag_tms_i ? UPD_IR : PAUSE_IR;
      PAUSE_IR: next_state = jtag_tms_i ? EX2_IR : PAUSE_IR;
      EX2_IR:   next_state = jtag_tms_i ? UPD_IR : SH_IR;
      UPD_IR:   next_state = jtag_tms_i ? SEL_DR : RTI;
      default:  next_state = TLR;
    endcase
  end

  // TAP state register.
  // TRST wins over any TCK edge seen in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= TLR;
    end else if (!jtag_trst_i) begin
      state <= TLR;
    end else if (rise) begin
      state <= next_state;
    end else begin
      state <= state;
    end
  end

  // Capture and shift on TCK rise, based on the state before the transition.
  // Shift registers hold through TRST. A later scan always re-captures first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ir_sr     <= '0;
      idcode_sr <= 32'h0000_0000;
      user_sr   <= 32'h0000_0000;
      bypass_sr <= 1'b0;
    end else if (jtag_trst_i && rise) begin
      case (state)
        CAP_IR: ir_sr <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
        SH_IR:  ir_sr <= {jtag_tdi_i, ir_sr[IR_WIDTH-1:1]};
        CAP_DR: begin
          if (sel_idcode) begin
            idcode_sr <= IDCODE_VAL;
          end else if (sel_user) begin
            user_sr <= user_dr_i;
          end else begin
            bypass_sr <= 1'b0;
          end
        end
        SH_DR: begin
          if (sel_idcode) begin
            idcode_sr <= {jtag_tdi_i, idcode_sr[31:1]};
          end else if (sel_user) begin
            user_sr <= {jtag_tdi_i, user_sr[31:1]};
          end else begin
            bypass_sr <= jtag_tdi_i;
          end
        end
        default: begin
          ir_sr <= ir_sr;
        end
      endcase
    end else begin
      ir_sr <= ir_sr;
    end
  end

  // LSB of the selected data register, used as the TDO source in Shift-DR.
  always_comb begin
    dr_lsb = bypass_sr;
    if (sel_idcode) begin
      dr_lsb = idcode_sr[0];
    end else if (sel_user) begin
      dr_lsb = user_sr[0];
    end else begin
      dr_lsb = bypass_sr;
    end
  end

  // TDO launches on TCK fall in the shift states and holds everywhere else.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tdo <= 1'b0;
    end else if (!jtag_trst_i) begin
      tdo <= 1'b0;
    end else if (fall && (state == SH_DR)) begin
      tdo <= dr_lsb;
    end else if (fall && (state == SH_IR)) begin
      tdo <= ir_sr[0];
    end else begin
      tdo <= tdo;
    end
  end

  // Active instruction register.
  // It is forced to IDCODE in TLR. This includes the edge that enters TLR,
  // so ir_o and tap_state_o agree on every cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ir <= INSTR_IDCODE;
    end else if (!jtag_trst_i) begin
      ir <= INSTR_IDCODE;
    end else if ((state == TLR) || (rise && (next_state == TLR))) begin
      ir <= INSTR_IDCODE;
    end else if (fall && (state == UPD_IR)) begin
      ir <= ir_sr;
    end else begin
      ir <= ir;
    end
  end

  // USER parallel output and its write strobe.
  // The value survives TRST and TLR; only rst_i clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      user_dr     <= 32'h0000_0000;
      user_update <= 1'b0;
    end else if (!jtag_trst_i) begin
      user_dr     <= user_dr;
      user_update <= 1'b0;
    end else if (fall && (state == UPD_DR) && sel_user) begin
      user_dr     <= user_sr;
      user_update <= 1'b1;
    end else begin
      user_dr     <= user_dr;
      user_update <= 1'b0;
    end
  end

  assign jtag_tdo_o    = tdo;
  assign tap_state_o   = state;
  assign ir_o          = ir;
  assign user_dr_o     = user_dr;
  assign user_update_o = user_update;

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Testbench for jtag_tap_sampled.
// A queue-based reference model of the TAP is kept alongside the stimulus:
//   - the state graph is held as lookup tables
//   - data and instruction registers are bit queues, LSB first
// After every TCK half period the expected outputs are pushed to a
// scoreboard queue that a separate monitor drains and compares. USER updates
// are predicted into their own queue and checked whenever the DUT pulses
// user_update_o.
module tb_jtag_tap_sampled;

  logic        clk = 1'b0;
  logic        rst;
  logic        tck;
  logic        tms;
  logic        tdi;
  logic        trst;
  logic        tdo;
  logic [3:0]  tap_state;
  logic [4:0]  ir;
  logic [31:0] user_dr_in;
  logic [31:0] user_dr_out;
  logic        user_update;

  jtag_tap_sampled dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .jtag_tck_i    (tck),
    .jtag_tms_i    (tms),
    .jtag_tdi_i    (tdi),
    .jtag_trst_i   (trst),
    .jtag_tdo_o    (tdo),
    .tap_state_o   (tap_state),
    .ir_o          (ir),
    .user_dr_i     (user_dr_in),
    .user_dr_o     (user_dr_out),
    .user_update_o (user_update)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic [4:0]  ir;
    logic        tdo;
    logic [31:0] udr;
  } snap_t;

  snap_t       snap_q[$];
  event        snap_ev;
  logic [31:0] exp_upd[$];
  int          upd_count = 0;

  // Next-state tables indexed by the IEEE state code (TMS=0 and TMS=1).
  int ns0[16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
  int ns1[16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

  // Reference model state.
  int          m_st;
  logic [4:0]  m_ir;
  logic        m_tdo;
  logic [31:0] m_udr;
  bit          dq[$];
  bit          iq[$];
  bit          cap[$];
  bit          rand_udr = 1'b0;
  logic [31:0] idv = 32'h149511C3;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] q2v(bit q[$]);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < q.size() && i < 32; i++) v[i] = q[i];
    return v;
  endfunction

  task automatic model_rise(bit t, bit d);
    case (m_st)
      14: begin
        iq.delete();
        iq.push_back(1'b1);
        for (int i = 1; i < 5; i++) iq.push_back(1'b0);
      end
      6: begin
        dq.delete();
        if (m_ir == 5'h01) begin
          for (int i = 0; i < 32; i++) dq.push_back(idv[i]);
        end else if (m_ir == 5'h08) begin
          for (int i = 0; i < 32; i++) dq.push_back(user_dr_in[i]);
        end else begin
          dq.push_back(1'b0);
        end
      end
      10: if (iq.size() > 0) begin void'(iq.pop_front()); iq.push_back(d); end
      2:  if (dq.size() > 0) begin void'(dq.pop_front()); dq.push_back(d); end
      default: ;
    endcase
    m_st = t ? ns1[m_st] : ns0[m_st];
    if (m_st == 15) m_ir = 5'h01;
  endtask

  task automatic model_fall();
    logic [31:0] v;
    case (m_st)
      2:  m_tdo = (dq.size() > 0) ? dq[0] : 1'b0;
      10: m_tdo = (iq.size() > 0) ? iq[0] : 1'b0;
      13: begin v = q2v(iq); m_ir = v[4:0]; end
      5: begin
        if (m_ir == 5'h08) begin
          m_udr = q2v(dq);
          exp_upd.push_back(m_udr);
        end
      end
      default: ;
    endcase
  endtask

  task automatic push_snap();
    snap_t s;
    s.st  = 4'(m_st);
    s.ir  = m_ir;
    s.tdo = m_tdo;
    s.udr = m_udr;
    snap_q.push_back(s);
    -> snap_ev;
  endtask

  task automatic hold(int n);
    repeat (n) @(negedge clk);
  endtask

  // One full TCK period. Entered and left at a clk falling edge with TCK low.
  task automatic tck_cycle(bit t, bit d);
    if (rand_udr && ($urandom_range(0, 7) == 0)) user_dr_in = $urandom;
    tms = t;
    tdi = d;
    tck = 1'b1;
    model_rise(t, d);
    hold($urandom_range(1, 3));
    push_snap();
    tck = 1'b0;
    model_fall();
    hold($urandom_range(1, 3));
    if (m_st == 2 || m_st == 10) cap.push_back(tdo);
    push_snap();
  endtask

  task automatic do_trst(bit with_rise);
    trst = 1'b0;
    if (with_rise) tck = 1'b1;
    m_st  = 15;
    m_ir  = 5'h01;
    m_tdo = 1'b0;
    hold(1);
    push_snap();
    hold(1);
    trst = 1'b1;
    hold(1);
    push_snap();
    if (tck) begin
      tck = 1'b0;
      model_fall();
      hold(1);
      push_snap();
    end
  endtask

  task automatic goto_tlr();
    repeat (5) tck_cycle(1'b1, 1'($urandom_range(0, 1)));
  endtask

  // IR scan from Run-Test/Idle back to Run-Test/Idle.
  task automatic scan_ir(logic [4:0] v);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tck_cycle(i == 4, v[i]);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  // DR scan from Run-Test/Idle back to Run-Test/Idle.
  // It optionally parks in Pause-DR after bit pause_at.
  task automatic scan_dr(int n, logic [31:0] v, int pause_at);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      tck_cycle((i == n - 1) || (i == pause_at), v[i]);
      if (i == pause_at && i != n - 1) begin
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
      end
    end
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  // Scoreboard monitor: compares every predicted snapshot with the DUT.
  initial begin : scoreboard
    snap_t s;
    forever begin
      @(snap_ev);
      while (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        checks++;
        if (tap_state !== s.st || ir !== s.ir || tdo !== s.tdo || user_dr_out !== s.udr) begin
          errors++;
          $display("FAIL snapshot @%0t: got st=%h ir=%h tdo=%b udr=%h expected st=%h ir=%h tdo=%b udr=%h",
                   $time, tap_state, ir, tdo, user_dr_out, s.st, s.ir, s.tdo, s.udr);
        end
      end
    end
  end

  // Update monitor: each pulse must match the next predicted USER write.
  always @(negedge clk) begin
    if (user_update === 1'b1) begin
      upd_count++;
      checks++;
      if (exp_upd.size() == 0) begin
        errors++;
        $display("FAIL user_update: unexpected pulse with user_dr_o=%h", user_dr_out);
      end else begin
        logic [31:0] e;
        e = exp_upd.pop_front();
        if (user_dr_out !== e) begin
          errors++;
          $display("FAIL user_update value: got %h expected %h", user_dr_out, e);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int u0;
    logic [4:0] pick;
    rst = 1'b1;
    tck = 1'b0;
    tms = 1'b1;
    tdi = 1'b0;
    trst = 1'b1;
    user_dr_in = 32'h0;
    m_st  = 15;
    m_ir  = 5'h01;
    m_tdo = 1'b0;
    m_udr = 32'h0;
    hold(3);
    check("reset_state", tap_state, 4'hF);
    check("reset_ir", ir, 5'h01);
    check("reset_tdo", tdo, 1'b0);
    check("reset_user_dr", user_dr_out, 32'h0);
    check("reset_update", user_update, 1'b0);
    rst = 1'b0;
    hold(1);

    goto_tlr();
    check("tlr_state", tap_state, 4'hF);
    check("tlr_ir", ir, 5'h01);
    check("tlr_tdo", tdo, 1'b0);
    tck_cycle(1'b0, 1'b0);

    // IDCODE read
    cap.delete();
    scan_dr(32, 32'h0, -1);
    check("idcode_len", cap.size(), 32);
    check("idcode_tdo", q2v(cap), 32'h149511C3);

    // IR capture and load
    cap.delete();
    scan_ir(5'h08);
    check("ir_capture_tdo", q2v(cap), 32'h0000_0001);
    check("ir_loaded", ir, 5'h08);

    // BYPASS: TDI 1,0,1,1,0,0,1,0 returns 0 then TDI delayed by one bit
    scan_ir(5'h1F);
    check("bypass_ir", ir, 5'h1F);
    cap.delete();
    scan_dr(8, 32'h0000_004D, -1);
    check("bypass_tdo", q2v(cap), 32'h0000_009A);

    // USER write and read-back
    scan_ir(5'h08);
    user_dr_in = 32'h12345678;
    u0 = upd_count;
    cap.delete();
    scan_dr(32, 32'hDEADBEEF, -1);
    hold(1);
    check("user_capture_tdo", q2v(cap), 32'h12345678);
    check("user_dr_out", user_dr_out, 32'hDEADBEEF);
    check("user_update_count", upd_count - u0, 1);

    // TRST after 10 USER shift bits
    u0 = upd_count;
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tck_cycle(1'b0, 1'($urandom_range(0, 1)));
    trst = 1'b0;
    m_st  = 15;
    m_ir  = 5'h01;
    m_tdo = 1'b0;
    hold(1);
    check("trst_state", tap_state, 4'hF);
    check("trst_ir", ir, 5'h01);
    check("trst_user_dr", user_dr_out, 32'hDEADBEEF);
    push_snap();
    trst = 1'b1;
    hold(2);
    push_snap();
    check("trst_no_update", upd_count - u0, 0);

    // TRST arriving in the same cycle as a TCK rise
    tck_cycle(1'b0, 1'b0);
    do_trst(1'b1);

    // Randomized scans mixed with random TMS walks
    rand_udr = 1'b1;
    for (int r = 0; r < 12; r++) begin
      goto_tlr();
      tck_cycle(1'b0, 1'b0);
      case ($urandom_range(0, 3))
        0:       pick = 5'h01;
        1:       pick = 5'h08;
        2:       pick = 5'h1F;
        default: pick = 5'($urandom_range(0, 31));
      endcase
      scan_ir(pick);
      scan_dr(32, $urandom, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30)) : -1);
      for (int k = 0; k < 25; k++) begin
        if ($urandom_range(0, 24) == 0) do_trst(1'($urandom_range(0, 1)));
        else tck_cycle($urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)));
      end
    end

    hold(3);
    check("pending_updates", exp_upd.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
